apb4_arbiter: RTL and testbench
===============================

# apb4_arbiter

Round-robin APB4 master arbiter sharing one APB4 completer port (e.g. `apb4_archinfo`) among `NUM_REQ` on-chip requesters. Each requester issues single transfers over a valid/ready command channel and receives a one-cycle response pulse. The block sequences the APB4 SETUP/ACCESS phases, returns read data and errors to the granted requester, and terminates hung transfers with a timeout error. It sits between requester logic and the `apb4_if` slave side of the peripheral.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width, multiple of 8.
- `TIMEOUT_CYC`, 256: maximum ACCESS cycles before forced error; 0 disables the timeout.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-requester command valid.
- `req_ready_o`  out  NUM_REQ  one-hot command accept.
- `req_write_i`  in  NUM_REQ  1 = write.
- `req_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at slice k.
- `req_wdata_i`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `req_wstrb_i`  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes.
- `rsp_valid_o`  out  NUM_REQ  one-hot, one-cycle response pulse.
- `rsp_rdata_o`  out  DATA_WIDTH  read data, shared; valid with `rsp_valid_o`.
- `rsp_err_o`  out  1  `pslverr_i` or timeout; valid with `rsp_valid_o`.
- `paddr_o`, `pwrite_o`, `pwdata_o`, `pstrb_o`, `pprot_o` (3 bits), `psel_o`, `penable_o`  out: APB4 request.
- `prdata_i`, `pready_i`, `pslverr_i`  in: APB4 completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**: if any `req_valid_i` is set, the round-robin picker selects requester g. `req_ready_o[g]`=1 combinationally in the same cycle. The command is registered and the state moves to SETUP. `req_ready_o` is 0 in all other states.
- **Round-robin**: the search starts at `last_grant+1` modulo `NUM_REQ`. `last_grant` updates on each accept. Reset value is `NUM_REQ-1`, so requester 0 has first priority.
- **SETUP**: `psel_o`=1, `penable_o`=0, address and control driven from registers. Always moves to ACCESS.
- **ACCESS**: `psel_o`=1, `penable_o`=1. Address and control are held stable until completion.
  - On `pready_i`=1: capture `prdata_i` (reads) or 0 (writes) and `pslverr_i`, then go to IDLE.
  - On timeout (counter reaches `TIMEOUT_CYC` ACCESS cycles without `pready_i`): `rsp_err_o`=1, `rsp_rdata_o`=0, then go to IDLE.
- **Response**: `rsp_valid_o[g]` is registered and pulses in the first IDLE cycle after completion. A new command may be accepted in that same cycle.
- `pprot_o` is fixed at 3'b000. `pstrb_o` is forced to 0 on reads. `pwdata_o` is 0 on reads.
- **Reset mid-transfer**: the transfer is abandoned silently (no response pulse). The APB bus is released on the next edge.

## Timing
- Reset values: `psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o`, `pstrb_o`, `pprot_o` all 0; `req_ready_o` 0; `rsp_valid_o` 0; `rsp_rdata_o` 0; `rsp_err_o` 0; state IDLE; timeout counter 0.
- Zero-wait-state latency:
  - accept at cycle 0
  - SETUP at cycle 1
  - ACCESS with `pready_i` at cycle 2
  - `rsp_valid_o` at cycle 3
- Back-to-back throughput is one transfer per 3 cycles.
- Each wait state adds one cycle.
- The timeout counter clears on entering ACCESS. With `TIMEOUT_CYC`=N, the error response appears N+1 cycles after ACCESS entry.
- `pready_i` arriving in the same cycle the counter expires counts as normal completion; `pready_i` wins.
- `req_valid_i` deasserting while the requester is not granted has no effect; the command is not latched.

## Structure
- Package `apb4_arbiter_pkg`: FSM state enum (`ARB_IDLE`, `ARB_SETUP`, `ARB_ACCESS`) and the `APB_PROT_DEFAULT` constant.
- Sub-module `rr_picker`: `NUM_REQ`-wide round-robin priority picker, one-hot output from request vector plus `last_grant` pointer. Combinational, instantiated once.
- Top level holds the FSM, command registers, timeout counter and response registers.
- The top level plugs into `apb4_if` through a thin bench wrapper.

## Test plan
- **Single read**: req0 reads address 0x0 from `apb4_archinfo`, zero wait.
  - `psel_o` at cycle 1, `penable_o` at cycle 2.
  - `rsp_valid_o`=2'b01 at cycle 3 with the peripheral's reset-value register data.
  - `rsp_err_o`=0.
- **Contention**: req0 and req1 both valid continuously after reset.
  - Grants are issued in order 0,1,0,1.
  - `rsp_valid_o` pulses 3 cycles apart, alternating one-hot.
- **Wait states**: `pready_i` held low 4 ACCESS cycles, then `prdata_i`=0xDEADBEEF.
  - `rsp_rdata_o`=0xDEADBEEF.
  - APB signals stable throughout.
  - Response at cycle 7.
- **Slave error**: write with `pslverr_i`=1 on completion.
  - `rsp_err_o`=1 and `rsp_valid_o` set for the writer.
  - Next command accepted in the response cycle.
- **Timeout**: `TIMEOUT_CYC`=8, `pready_i` tied 0.
  - `rsp_err_o`=1 and `rsp_rdata_o`=0 at cycle 11.
  - `psel_o`=0 afterwards.
- **Reset mid-ACCESS**: `rst_i` pulsed during a wait state.
  - All outputs 0 on the next edge; no `rsp_valid_o`.
  - Requester 0 has priority on the next contention.

Source files
------------

// File: rtl/apb4_arbiter_pkg.sv
// apb4_arbiter_pkg: FSM encoding and fixed APB attributes for the arbiter
package apb4_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS} arb_state_e;
    localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/apb4_arbiter_if.sv
// apb4_arbiter_if: APB4 bus between the arbiter (master) and one completer (slave)
interface apb4_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;
    modport master (
        output paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: one-hot round-robin pick, searching upward from the slot after last_i
module rr_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    logic found;
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && IW'(i) > last_i) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // wrap-around pass: slots up to and including the last grant
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && IW'(i) <= last_i) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apb4_arbiter.sv
// apb4_arbiter: round-robin arbiter sharing one APB4 completer among NUM_REQ requesters
module apb4_arbiter
    import apb4_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0]              req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb_i,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
    output logic                            rsp_err_o,
    apb4_arbiter_if.master                  apb
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;
    localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         last_q, last_d;
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]    pick;
    logic [IW-1:0]         pick_idx;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [SW-1:0]         sel_wstrb;
    logic                  expired;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    always_comb begin
        pick_idx  = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx  = IW'(i);
                sel_write = req_write_i[i];
                sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = req_wstrb_i[i*SW +: SW];
            end
        end
    end

    assign expired = TIMEOUT_CYC != 0 && cnt_q == TW'(TIMEOUT_CYC);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|pick) begin
                    req_ready_o = pick;
                    state_d     = ARB_SETUP;
                    last_d      = pick_idx;
                    owner_d     = pick;
                    write_d     = sel_write;
                    addr_d      = sel_addr;
                    wdata_d     = sel_write ? sel_wdata : '0;
                    wstrb_d     = sel_write ? sel_wstrb : '0;
                end
            end
            ARB_SETUP: begin
                state_d = ARB_ACCESS;
                cnt_d   = '0;
            end
            ARB_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // a completion in the expiry cycle is honoured as a normal response
                if (apb.pready || expired) begin
                    state_d     = ARB_IDLE;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = (apb.pready && !write_q) ? apb.prdata : '0;
                    rsp_err_d   = apb.pready ? apb.pslverr : 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            owner_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign apb.psel    = state_q != ARB_IDLE;
    assign apb.penable = state_q == ARB_ACCESS;
    assign apb.paddr   = addr_q;
    assign apb.pwrite  = write_q;
    assign apb.pwdata  = wdata_q;
    assign apb.pstrb   = wstrb_q;
    assign apb.pprot   = APB_PROT_DEFAULT;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_apb4_arbiter.sv
// tb_apb4_arbiter: scoreboard bench with a wait-state-programmable APB completer model
module tb_apb4_arbiter;
    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TO      = 8;
    localparam int IW      = $clog2(NUM_REQ);
    localparam logic [DW-1:0] ARCH_ID = 32'h4150_0104;

    typedef struct {
        logic [NUM_REQ-1:0] who;
        logic [DW-1:0]      data;
        logic               err;
        int                 cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ*SW-1:0] req_wstrb;
    logic [AW-1:0]         addr_a [NUM_REQ];
    logic [DW-1:0]         wdata_a [NUM_REQ];
    logic [SW-1:0]         wstrb_a [NUM_REQ];
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_err;
    logic [AW-1:0]         cur_addr;
    logic                  cur_wr;
    logic [DW-1:0]         cur_wd;
    logic [SW-1:0]         cur_ws;
    int                    cyc = 0;
    int                    wait_n, acc;
    logic                  slv_err;
    int                    n_cmp = 0, n_bad = 0;
    exp_t                  sb[$];
    exp_t                  mon_e;

    apb4_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb4_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .apb         (apb)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_addr[g*AW +: AW]  = addr_a[g];
        assign req_wdata[g*DW +: DW] = wdata_a[g];
        assign req_wstrb[g*SW +: SW] = wstrb_a[g];
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata_for(input logic [AW-1:0] a);
        return a == 32'h0 ? ARCH_ID : a == 32'h40 ? 32'hDEAD_BEEF : a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [NUM_REQ-1:0] oh(input logic [IW-1:0] k);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // completer: raises pready on the ACCESS cycle whose index equals wait_n (never if negative)
    always @(negedge clk) begin
        if (apb.psel && apb.penable) begin
            apb.pready  = wait_n >= 0 && acc == wait_n;
            apb.prdata  = apb.pready ? rdata_for(apb.paddr) : 32'hBAD0_BAD0;
            apb.pslverr = apb.pready && slv_err;
            acc++;
        end else begin
            acc         = 0;
            apb.pready  = 1'b0;
            apb.prdata  = 32'hBAD0_BAD0;
            apb.pslverr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (apb.psel) begin
            check("apb_addr",  64'(apb.paddr),  64'(cur_addr));
            check("apb_write", 64'(apb.pwrite), 64'(cur_wr));
            check("apb_wdata", 64'(apb.pwdata), 64'(cur_wd));
            check("apb_strb",  64'(apb.pstrb),  64'(cur_ws));
            check("apb_prot",  64'(apb.pprot),  64'(0));
        end
        if (|rsp_valid) begin
            if (sb.size() == 0) check("rsp_spurious", 64'(rsp_valid), 64'(0));
            else begin
                mon_e = sb.pop_front();
                check("rsp_who",   64'(rsp_valid), 64'(mon_e.who));
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.data));
                check("rsp_err",   64'(rsp_err),   64'(mon_e.err));
                check("rsp_cycle", 64'(cyc),       64'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input logic [IW-1:0] k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] ws, input int waits,
                         input logic serr, input logic want);
        exp_t e;
        logic timed;
        wait_n       = waits;
        slv_err      = serr;
        req_write[k] = wr;
        addr_a[k]    = a;
        wdata_a[k]   = wd;
        wstrb_a[k]   = ws;
        req_valid[k] = 1'b1;
        cur_addr     = a;
        cur_wr       = wr;
        cur_wd       = wr ? wd : '0;
        cur_ws       = wr ? ws : '0;
        #1;
        check("accept", 64'(req_ready), 64'(oh(k)));
        timed = waits < 0 || waits > TO;
        e.who  = oh(k);
        e.data = (timed || wr) ? '0 : rdata_for(a);
        e.err  = timed || serr;
        e.cyc  = cyc + (timed ? TO : waits) + 3;
        if (want) sb.push_back(e);
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic contend(input int n, input logic [IW-1:0] first);
        exp_t e;
        logic [IW-1:0] g;
        int got;
        g         = first;
        got       = 0;
        wait_n    = 0;
        slv_err   = 1'b0;
        addr_a[0] = 32'h100;
        addr_a[1] = 32'h200;
        req_write = '0;
        req_valid = '1;
        for (int t = 0; t < 3 * n + 6 && got < n; t++) begin
            #1;
            if (|req_ready) begin
                check("rr_grant", 64'(req_ready), 64'(oh(g)));
                check("rr_slot", 64'(t), 64'(3 * got));
                cur_addr = addr_a[g];
                cur_wr   = 1'b0;
                cur_wd   = '0;
                cur_ws   = '0;
                e.who    = oh(g);
                e.data   = rdata_for(addr_a[g]);
                e.err    = 1'b0;
                e.cyc    = cyc + 3;
                sb.push_back(e);
                got++;
                g = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
            end
            @(negedge clk);
        end
        req_valid = '0;
        check("rr_count", 64'(got), 64'(n));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        addr_a    = '{default: '0};
        wdata_a   = '{default: '0};
        wstrb_a   = '{default: '0};
        wait_n    = 0;
        slv_err   = 1'b0;
        cur_addr  = '0;
        cur_wr    = 1'b0;
        cur_wd    = '0;
        cur_ws    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_psel",    64'(apb.psel),    64'(0));
        check("rst_penable", 64'(apb.penable), 64'(0));
        check("rst_pwrite",  64'(apb.pwrite),  64'(0));
        check("rst_paddr",   64'(apb.paddr),   64'(0));
        check("rst_pwdata",  64'(apb.pwdata),  64'(0));
        check("rst_pstrb",   64'(apb.pstrb),   64'(0));
        check("rst_pprot",   64'(apb.pprot),   64'(0));
        check("rst_ready",   64'(req_ready),   64'(0));
        check("rst_rvalid",  64'(rsp_valid),   64'(0));
        check("rst_rdata",   64'(rsp_rdata),   64'(0));
        check("rst_err",     64'(rsp_err),     64'(0));
        rst = 1'b0;
        contend(4, 0);
        drain();
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 1'b1);
        check("setup_psel",    64'(apb.psel),    64'(1));
        check("setup_penable", 64'(apb.penable), 64'(0));
        @(negedge clk);
        #1;
        check("access_psel",    64'(apb.psel),    64'(1));
        check("access_penable", 64'(apb.penable), 64'(1));
        drain();
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 4, 1'b0, 1'b1);
        drain();
        issue(0, 1'b1, 32'h80, 32'h1234_5678, 4'b0101, 1, 1'b1, 1'b1);
        drain();
        issue(1, 1'b1, 32'h84, 32'hCAFE_F00D, 4'b1111, 0, 1'b0, 1'b1);
        drain();
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, -1, 1'b0, 1'b1);
        drain();
        check("to_psel_after", 64'(apb.psel), 64'(0));
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, TO, 1'b0, 1'b1);
        drain();
        issue(0, 1'b0, 32'h24, 32'h0, 4'h0, TO + 1, 1'b0, 1'b1);
        drain();
        issue(0, 1'b0, 32'h30, 32'h0, 4'h0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_psel",    64'(apb.psel),    64'(0));
        check("midrst_penable", 64'(apb.penable), 64'(0));
        check("midrst_paddr",   64'(apb.paddr),   64'(0));
        check("midrst_rvalid",  64'(rsp_valid),   64'(0));
        check("midrst_err",     64'(rsp_err),     64'(0));
        check("midrst_rdata",   64'(rsp_rdata),   64'(0));
        rst = 1'b0;
        contend(2, 0);
        drain();
        repeat (6) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
